// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared constants, state encoding and saturating arithmetic for the perceptron trainer
package perceptron_pkg;

    localparam int FRAC_BITS = 9;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam logic signed [DATA_W-1:0] ONE = 16'sd512;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EVAL   = 3'd3,
        ST_UPDATE = 3'd4
    } state_t;

    // a + d (or a - d when neg), evaluated in 17 bits and clamped to the Q6.9 range
    function automatic logic signed [DATA_W-1:0] sat_addsub(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] d,
        input logic                     neg
    );
        logic signed [DATA_W:0] sum;
        sum = neg ? ({a[DATA_W-1], a} - {d[DATA_W-1], d})
                  : ({a[DATA_W-1], a} + {d[DATA_W-1], d});
        if (sum > 17'sd32767)
            return 16'sh7fff;
        else if (sum < -17'sd32768)
            return 16'sh8000;
        else
            return sum[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/perceptron_train_ctrl_mac.sv
// rtl/perceptron_train_ctrl_mac.sv - combinational weighted sum and sign activation
module perceptron_mac
    import perceptron_pkg::*;
(
    input  logic signed [DATA_W-1:0] i_w1,
    input  logic signed [DATA_W-1:0] i_w2,
    input  logic signed [DATA_W-1:0] i_x1,
    input  logic signed [DATA_W-1:0] i_x2,
    input  logic signed [DATA_W-1:0] i_b,
    output logic                     o_pred
);

    logic signed [2*DATA_W-1:0] w_p1;
    logic signed [2*DATA_W-1:0] w_p2;
    logic signed [2*DATA_W+1:0] w_sum;

    // Q12.18 products; the bias is moved up by FRAC_BITS to share their binary point
    assign w_p1  = i_w1 * i_x1;
    assign w_p2  = i_w2 * i_x2;
    assign w_sum = {{2{w_p1[2*DATA_W-1]}}, w_p1}
                 + {{2{w_p2[2*DATA_W-1]}}, w_p2}
                 + {{FRAC_BITS{i_b[DATA_W-1]}}, i_b, {FRAC_BITS{1'b0}}};

    // pred = 1 encodes +1 (sum >= 0), pred = 0 encodes -1
    assign o_pred = ~w_sum[2*DATA_W+1];

endmodule

// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - sample sequencer and perceptron learning engine
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_SAMPLES  = 1024,
    parameter int MAX_EPOCHS = 16,
    parameter int LR_SHIFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              mem_ena,
    output logic              wr_rd,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] x1_data,
    input  logic [DATA_W-1:0] x2_data,
    input  logic [DATA_W-1:0] t_data,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] b,
    output logic [7:0]        epochs,
    output logic [10:0]       err_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_SAMPLES - 1);
    localparam logic [7:0]        LAST_EPOCH = 8'(MAX_EPOCHS - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      w_finish;
    logic                      w_last_sample;
    logic [10:0]               w_ep_err;
    logic                      w_pred;
    logic                      w_unused_t;

    logic [ADDR_W-1:0]         r_idx;
    logic signed [DATA_W-1:0]  r_x1;
    logic signed [DATA_W-1:0]  r_x2;
    logic                      r_t_neg;
    logic                      r_err;
    logic [10:0]               r_ep_err;
    logic signed [DATA_W-1:0]  r_w1;
    logic signed [DATA_W-1:0]  r_w2;
    logic signed [DATA_W-1:0]  r_b;
    logic [7:0]                r_epochs;
    logic [10:0]               r_err_count;
    logic                      r_converged;
    logic                      r_done;

    // only the label's sign carries information
    assign w_unused_t    = ^t_data[DATA_W-2:0];
    assign w_last_sample = (r_idx == LAST_IDX);
    assign w_ep_err      = r_ep_err + {10'd0, r_err};

    perceptron_mac u_mac (
        .i_w1   (r_w1),
        .i_w2   (r_w2),
        .i_x1   (r_x1),
        .i_x2   (r_x2),
        .i_b    (r_b),
        .o_pred (w_pred)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // next-state: four cycles per sample, leave at an error-free epoch or the epoch limit
    always_comb begin
        w_state_next = r_state;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_ISSUE;
            ST_ISSUE:  w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_EVAL;
            ST_EVAL:   w_state_next = ST_UPDATE;
            ST_UPDATE: begin
                w_state_next = ST_ISSUE;
                if (w_last_sample && (w_ep_err == 11'd0 || r_epochs == LAST_EPOCH)) begin
                    w_state_next = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // datapath: operand capture, error flag, weight update and epoch bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_t_neg     <= 1'b0;
            r_err       <= 1'b0;
            r_ep_err    <= '0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_b         <= '0;
            r_epochs    <= '0;
            r_err_count <= '0;
            r_converged <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_idx       <= '0;
                        r_ep_err    <= '0;
                        r_w1        <= '0;
                        r_w2        <= '0;
                        r_b         <= '0;
                        r_epochs    <= '0;
                        r_err_count <= '0;
                        r_converged <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_x1    <= x1_data;
                    r_x2    <= x2_data;
                    r_t_neg <= t_data[DATA_W-1];
                end
                ST_EVAL: r_err <= (w_pred == r_t_neg);
                ST_UPDATE: begin
                    if (r_err) begin
                        r_w1 <= sat_addsub(r_w1, r_x1 >>> LR_SHIFT, r_t_neg);
                        r_w2 <= sat_addsub(r_w2, r_x2 >>> LR_SHIFT, r_t_neg);
                        r_b  <= sat_addsub(r_b, ONE >>> LR_SHIFT, r_t_neg);
                    end
                    if (!w_last_sample) begin
                        r_idx    <= r_idx + ADDR_W'(1);
                        r_ep_err <= w_ep_err;
                    end else begin
                        r_idx       <= '0;
                        r_ep_err    <= '0;
                        r_epochs    <= r_epochs + 8'd1;
                        r_err_count <= w_ep_err;
                        if (w_ep_err == 11'd0) r_converged <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign mem_ena   = (r_state == ST_ISSUE);
    assign wr_rd     = 1'b0;
    assign addr      = r_idx;
    assign done      = r_done;
    assign converged = r_converged;
    assign w1        = r_w1;
    assign w2        = r_w2;
    assign b         = r_b;
    assign epochs    = r_epochs;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - directed self-checking bench for perceptron_train_ctrl
module tb_perceptron_train_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_a, start_b, start_c;
    logic busy_a, done_a, conv_a, ena_a, wr_a;
    logic busy_b, done_b, conv_b, ena_b, wr_b;
    logic busy_c, done_c, conv_c, ena_c, wr_c;
    logic [9:0]  addr_a, addr_b, addr_c;
    logic [15:0] x1_a, x2_a, t_a, x1_b, x2_b, t_b, x1_c, x2_c, t_c;
    logic [15:0] w1_a, w2_a, b_a, w1_b, w2_b, b_b, w1_c, w2_c, b_c;
    logic [7:0]  ep_a, ep_b, ep_c;
    logic [10:0] ec_a, ec_b, ec_c;

    logic [15:0] mx1_a [0:3], mx2_a [0:3], mt_a [0:3];
    logic [15:0] mx1_b [0:3], mx2_b [0:3], mt_b [0:3];
    logic [15:0] mx1_c [0:3], mx2_c [0:3], mt_c [0:3];

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;
    logic done_sel;
    int cyc;
    int ena_total = 0;
    int n_done_a = 0;
    int ena_run = 0;
    int ena_max = 0;
    logic wr_seen = 1'b0;
    int addr_log[$];

    perceptron_train_ctrl #(.N_SAMPLES(1), .MAX_EPOCHS(16), .LR_SHIFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .converged(conv_a), .mem_ena(ena_a), .wr_rd(wr_a), .addr(addr_a),
        .x1_data(x1_a), .x2_data(x2_a), .t_data(t_a), .w1(w1_a), .w2(w2_a), .b(b_a),
        .epochs(ep_a), .err_count(ec_a));

    perceptron_train_ctrl #(.N_SAMPLES(2), .MAX_EPOCHS(4), .LR_SHIFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .converged(conv_b), .mem_ena(ena_b), .wr_rd(wr_b), .addr(addr_b),
        .x1_data(x1_b), .x2_data(x2_b), .t_data(t_b), .w1(w1_b), .w2(w2_b), .b(b_b),
        .epochs(ep_b), .err_count(ec_b));

    perceptron_train_ctrl #(.N_SAMPLES(3), .MAX_EPOCHS(16), .LR_SHIFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .converged(conv_c), .mem_ena(ena_c), .wr_rd(wr_c), .addr(addr_c),
        .x1_data(x1_c), .x2_data(x2_c), .t_data(t_c), .w1(w1_c), .w2(w2_c), .b(b_c),
        .epochs(ep_c), .err_count(ec_c));

    assign done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    // one-cycle-latency sample memories
    always @(posedge clk) begin
        if (ena_a) begin x1_a <= mx1_a[addr_a[1:0]]; x2_a <= mx2_a[addr_a[1:0]]; t_a <= mt_a[addr_a[1:0]]; end
        if (ena_b) begin x1_b <= mx1_b[addr_b[1:0]]; x2_b <= mx2_b[addr_b[1:0]]; t_b <= mt_b[addr_b[1:0]]; end
        if (ena_c) begin x1_c <= mx1_c[addr_c[1:0]]; x2_c <= mx2_c[addr_c[1:0]]; t_c <= mt_c[addr_c[1:0]]; end
    end

    // bus monitors
    always @(posedge clk) begin
        ena_total <= ena_total + int'(ena_a) + int'(ena_b) + int'(ena_c);
        if (done_a) n_done_a <= n_done_a + 1;
        if (wr_a | wr_b | wr_c) wr_seen <= 1'b1;
        if (ena_c) begin
            addr_log.push_back(int'(addr_c));
            ena_run <= ena_run + 1;
            if (ena_run + 1 > ena_max) ena_max <= ena_run + 1;
        end else begin
            ena_run <= 0;
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_ctrl"}, {busy_a, done_a, conv_a, ena_a, wr_a, addr_a}, 0);
        check({tag, "_w1"}, $signed(w1_a), 0);
        check({tag, "_w2"}, $signed(w2_a), 0);
        check({tag, "_b"}, $signed(b_a), 0);
        check({tag, "_cnt"}, {ep_a, ec_a}, 0);
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // pulses start, returns the cycle index (E+n) at which done is seen
    task automatic run(input int s, input int pert, output int n);
        sel = s;
        @(negedge clk); set_start(s, 1'b1);
        @(negedge clk); set_start(s, 1'b0);
        n = 1;
        while (done_sel !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            set_start(s, n == pert);
        end
        set_start(s, 1'b0);
    endtask

    task automatic check_single(input string tag, input int n);
        check({tag, "_done_cyc"}, n, 9);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_conv"}, conv_a, 1);
        check({tag, "_epochs"}, ep_a, 2);
        check({tag, "_errcnt"}, ec_a, 0);
        check({tag, "_w1"}, $signed(w1_a), -512);
        check({tag, "_w2"}, $signed(w2_a), 0);
        check({tag, "_b"}, $signed(b_a), -512);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mx1_a[i] = 16'd0; mx2_a[i] = 16'd0; mt_a[i] = 16'd0;
            mx1_b[i] = 16'd0; mx2_b[i] = 16'd0; mt_b[i] = 16'd0;
            mx1_c[i] = 16'd512; mx2_c[i] = 16'd1024; mt_c[i] = 16'hFE00;
        end
        mx1_a[0] = 16'd512;   mt_a[0] = 16'hFE00;
        mx1_b[0] = 16'd20000; mt_b[0] = 16'd512;
        mx1_b[1] = 16'd20000; mt_b[1] = 16'hFE00;

        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_a("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (100) @(negedge clk);
        check("idle_mem_ena", ena_total, 0);
        check("idle_busy", busy_a, 0);

        run(0, 0, cyc);
        check_single("single", cyc);
        @(negedge clk);
        check("single_done_pulse", done_a, 0);
        check("single_conv_hold", conv_a, 1);

        run(0, 3, cyc);
        check_single("restart_ignored", cyc);

        sel = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_epochs", ep_a, 1);
        check("mid_errcnt", ec_a, 1);
        check("mid_busy", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero_a("midrst");
        cyc = n_done_a;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_no_done", n_done_a, cyc);
        check("midrst_idle", busy_a, 0);
        run(0, 0, cyc);
        check_single("after_rst", cyc);

        run(1, 0, cyc);
        check("nonsep_done_cyc", cyc, 33);
        check("nonsep_conv", conv_b, 0);
        check("nonsep_epochs", ep_b, 4);
        check("nonsep_errcnt", ec_b, 2);
        check("nonsep_w1", $signed(w1_b), -20000);
        check("nonsep_w2", $signed(w2_b), 0);
        check("nonsep_b", $signed(b_b), -512);

        run(2, 0, cyc);
        check("addr_done_cyc", cyc, 25);
        check("addr_conv", conv_c, 1);
        check("addr_epochs", ep_c, 2);
        check("lr_w1", $signed(w1_c), -256);
        check("lr_w2", $signed(w2_c), -512);
        check("lr_b", $signed(b_c), -256);
        check("addr_count", addr_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < addr_log.size()) check($sformatf("addr_seq_%0d", i), addr_log[i], i % 3);
        check("ena_width", ena_max, 1);
        check("wr_rd_low", wr_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
